// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    RESP    = 2'd3
  } state_t;

  function automatic int idx_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Valid/tag/data storage for one-word cache lines: async read, sync write, valid bits cleared on rst.
module dcache_line_ram
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0]      data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller between the
// MEM stage and a req/ack memory bus; hits answer in the same cycle.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = 32 - IDX_W;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic [31:0]      lookup_addr;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             wr_en;
  logic [31:0]      wr_data;

  // Outside IDLE the cpu_* inputs are not trusted, so lookups use the latched address.
  assign lookup_addr = (state_q == IDLE) ? cpu_addr : addr_q;
  assign hit         = rd_valid && (rd_tag == lookup_addr[31:IDX_W]);

  dcache_line_ram #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_line_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_addr[IDX_W-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (addr_q[IDX_W-1:0]),
    .wr_tag   (addr_q[31:IDX_W]),
    .wr_data  (wr_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    stall     = 1'b0;
    cpu_rdata = 32'd0;
    wr_en     = 1'b0;
    wr_data   = wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = WR_THRU;
          stall   = 1'b1;
        end else if (cpu_rd && hit) begin
          cpu_rdata = rd_data;
          hit_d     = (&hit_q) ? hit_q : hit_q + CNT_W'(1'b1);
        end else if (cpu_rd) begin
          addr_d  = cpu_addr;
          state_d = RD_MISS;
          stall   = 1'b1;
          miss_d  = (&miss_q) ? miss_q : miss_q + CNT_W'(1'b1);
        end else begin
          cpu_rdata = 32'd0;
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_data = mem_rdata;
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          state_d = RD_MISS;
        end
      end
      WR_THRU: begin
        stall = 1'b1;
        if (mem_ack) begin
          // Keep a resident copy coherent; absent lines are not allocated.
          wr_en   = hit;
          wr_data = wdata_q;
          rdata_d = 32'd0;
          state_d = RESP;
        end else begin
          state_d = WR_THRU;
        end
      end
      RESP: begin
        cpu_rdata = rdata_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign mem_req   = (state_q == RD_MISS) || (state_q == WR_THRU);
  assign mem_we    = (state_q == WR_THRU);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a fixed-latency req/ack memory model.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt, miss_cnt;

  logic [31:0] cpu_rdata4, mem_addr4, mem_wdata4;
  logic        stall4, mem_req4, mem_we4;
  logic [3:0]  hit_cnt4, miss_cnt4;

  logic [31:0] mem [0:2047];
  int          lat = 3;
  int          ack_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  dcache_ctrl #(.LINES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Narrow-counter twin fed identical stimulus; only its saturation is checked.
  dcache_ctrl #(.LINES(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata4), .stall(stall4), .mem_req(mem_req4),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack in the lat-th cycle that mem_req has been high.
  always @(negedge clk) begin
    if (mem_req) begin
      ack_cnt <= ack_cnt + 1;
      if (ack_cnt + 1 == lat) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[mem_addr[10:0]];
        if (mem_we) mem[mem_addr[10:0]] <= mem_wdata;
      end else begin
        mem_ack <= 1'b0;
      end
    end else begin
      ack_cnt <= 0;
      mem_ack <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (mem_ack === 1'b1) begin
      tests++;
      if (mem_req !== 1'b1) begin
        fails++;
        $display("FAIL ack_without_req: mem_req=%b required 1", mem_req);
      end
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, output int ncyc, output logic [31:0] rdata,
                           output logic saw_req, output logic req_we, output logic addr_ok,
                           output logic req_end);
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    #2;
    ncyc = 0; saw_req = 1'b0; req_we = 1'b0; addr_ok = 1'b1;
    while (stall === 1'b1 && ncyc < 50) begin
      ncyc++;
      @(negedge clk); #2;
      if (mem_req === 1'b1) begin
        saw_req = 1'b1;
        req_we  = mem_we;
        if (mem_addr !== addr || (wr && mem_wdata !== wd)) addr_ok = 1'b0;
      end
    end
    if (ncyc >= 50) begin
      tests++; fails++;
      $display("FAIL access_timeout: addr=%0d still stalled after %0d cycles", addr, ncyc);
    end
    rdata   = cpu_rdata;
    req_end = mem_req;
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", stall); end
    tests++; if (cpu_rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
    tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL rst_req: req=%b we=%b want 0 0", mem_req, mem_we); end
    tests++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin fails++; $display("FAIL rst_bus: addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
    tests++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt: hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_cold_read();
    int n; logic [31:0] rd; logic sr, we, ok, re;
    do_access(1'b1, 1'b0, 32'd1000, 32'd0, n, rd, sr, we, ok, re);
    tests++; if (n !== 4) begin fails++; $display("FAIL cold_stall: got %0d cycles want 4", n); end
    tests++; if (rd !== 32'h0000_0005) begin fails++; $display("FAIL cold_rdata: got %h want 5", rd); end
    tests++; if (miss_cnt !== 16'd1) begin fails++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    tests++; if (!sr || we !== 1'b0 || !ok) begin fails++; $display("FAIL cold_bus: req=%b we=%b addr_ok=%b want 1 0 1", sr, we, ok); end
    tests++; if (re !== 1'b0) begin fails++; $display("FAIL cold_req_after_ack: got %b want 0", re); end
  endtask

  task automatic test_hit();
    int n; logic [31:0] rd; logic sr, we, ok, re;
    do_access(1'b1, 1'b0, 32'd1000, 32'd0, n, rd, sr, we, ok, re);
    tests++; if (n !== 0 || sr !== 1'b0) begin fails++; $display("FAIL hit_nostall: cycles=%0d req=%b want 0 0", n, sr); end
    tests++; if (rd !== 32'h0000_0005) begin fails++; $display("FAIL hit_rdata: got %h want 5", rd); end
    tests++; if (hit_cnt !== 16'd1) begin fails++; $display("FAIL hit_cnt: got %0d want 1", hit_cnt); end
  endtask

  task automatic test_write_hit();
    int n; logic [31:0] rd; logic sr, we, ok, re;
    do_access(1'b0, 1'b1, 32'd1000, 32'hDEAD_BEEF, n, rd, sr, we, ok, re);
    tests++; if (n !== 4) begin fails++; $display("FAIL wr_stall: got %0d cycles want 4", n); end
    tests++; if (!sr || we !== 1'b1 || !ok) begin fails++; $display("FAIL wr_bus: req=%b we=%b addr_ok=%b want 1 1 1", sr, we, ok); end
    tests++; if (mem[1000] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_mem: got %h want deadbeef", mem[1000]); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL wr_resp_rdata: got %h want 0", rd); end
    do_access(1'b1, 1'b0, 32'd1000, 32'd0, n, rd, sr, we, ok, re);
    tests++; if (n !== 0 || rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_then_hit: cycles=%0d rdata=%h want 0 deadbeef", n, rd); end
    tests++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin fails++; $display("FAIL wr_counts: hit=%0d miss=%0d want 2 1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_write_no_alloc();
    int n; logic [31:0] rd; logic sr, we, ok, re;
    mem[1017] <= 32'h0000_0011;
    do_access(1'b0, 1'b1, 32'd1017, 32'h1234_5678, n, rd, sr, we, ok, re);
    tests++; if (mem[1017] !== 32'h1234_5678) begin fails++; $display("FAIL noalloc_mem: got %h want 12345678", mem[1017]); end
    do_access(1'b1, 1'b0, 32'd1017, 32'd0, n, rd, sr, we, ok, re);
    tests++; if (n !== 4 || rd !== 32'h1234_5678) begin fails++; $display("FAIL noalloc_read: cycles=%0d rdata=%h want 4 12345678", n, rd); end
    tests++; if (miss_cnt !== 16'd2) begin fails++; $display("FAIL noalloc_miss_cnt: got %0d want 2", miss_cnt); end
  endtask

  task automatic test_conflict();
    int n; logic [31:0] rd; logic sr, we, ok, re;
    pulse_reset();
    mem[1016] <= 32'h0000_0077;
    do_access(1'b1, 1'b0, 32'd1000, 32'd0, n, rd, sr, we, ok, re);
    tests++; if (n !== 4 || rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL conf_first: cycles=%0d rdata=%h want 4 deadbeef", n, rd); end
    do_access(1'b1, 1'b0, 32'd1016, 32'd0, n, rd, sr, we, ok, re);
    tests++; if (n !== 4 || rd !== 32'h0000_0077) begin fails++; $display("FAIL conf_second: cycles=%0d rdata=%h want 4 77", n, rd); end
    do_access(1'b1, 1'b0, 32'd1000, 32'd0, n, rd, sr, we, ok, re);
    tests++; if (n !== 4 || rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL conf_evicted: cycles=%0d rdata=%h want 4 deadbeef", n, rd); end
    tests++; if (miss_cnt !== 16'd3 || hit_cnt !== 16'd0) begin fails++; $display("FAIL conf_counts: miss=%0d hit=%0d want 3 0", miss_cnt, hit_cnt); end
  endtask

  task automatic test_reset_mid_miss();
    int n; logic [31:0] rd; logic sr, we, ok, re;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'd1016;
    @(negedge clk); #2;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL mid_req_before: got %b want 1", mem_req); end
    #1 rst = 1'b1; cpu_rd = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL mid_async_drop: req=%b stall=%b want 0 0", mem_req, stall); end
    tests++; if (miss_cnt !== 16'd0) begin fails++; $display("FAIL mid_cnt_clear: got %0d want 0", miss_cnt); end
    @(negedge clk); rst = 1'b0;
    do_access(1'b1, 1'b0, 32'd1000, 32'd0, n, rd, sr, we, ok, re);
    tests++; if (n !== 4 || rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mid_valid_clear: cycles=%0d rdata=%h want 4 deadbeef", n, rd); end
    tests++; if (miss_cnt !== 16'd1) begin fails++; $display("FAIL mid_miss_cnt: got %0d want 1", miss_cnt); end
  endtask

  task automatic test_rd_wr_both();
    int n; logic [31:0] rd; logic sr, we, ok, re;
    do_access(1'b1, 1'b1, 32'd1020, 32'hCAFE_0001, n, rd, sr, we, ok, re);
    tests++; if (n !== 4 || we !== 1'b1 || !ok) begin fails++; $display("FAIL both_write: cycles=%0d we=%b addr_ok=%b want 4 1 1", n, we, ok); end
    tests++; if (mem[1020] !== 32'hCAFE_0001) begin fails++; $display("FAIL both_mem: got %h want cafe0001", mem[1020]); end
    tests++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin fails++; $display("FAIL both_counts: miss=%0d hit=%0d want 1 0", miss_cnt, hit_cnt); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL both_rdata: got %h want 0", rd); end
  endtask

  task automatic test_saturation();
    int n; logic [31:0] rd; logic sr, we, ok, re;
    int stalls = 0;
    for (int i = 0; i < 20; i++) begin
      do_access(1'b1, 1'b0, 32'd1000, 32'd0, n, rd, sr, we, ok, re);
      stalls += n;
    end
    tests++; if (stalls !== 0) begin fails++; $display("FAIL sat_hits_nostall: got %0d stall cycles want 0", stalls); end
    tests++; if (hit_cnt !== 16'd20) begin fails++; $display("FAIL sat_hit_cnt16: got %0d want 20", hit_cnt); end
    tests++; if (hit_cnt4 !== 4'd15) begin fails++; $display("FAIL sat_hit_cnt4: got %0d want 15", hit_cnt4); end
  endtask

  initial begin
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
    mem[1000] <= 32'h0000_0005;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_cold_read();
    test_hit();
    test_write_hit();
    test_write_no_alloc();
    test_conflict();
    test_reset_mid_miss();
    test_rd_wr_both();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
